serialadd_n: RTL and testbench

Parametrised N-channel bit-serial adder/subtractor, the next generation of the fixed 4-input `serialadd`. It sums N LSB-first serial operand streams of LEN bits, with add or subtract selectable per channel per word. Word framing uses the same isync/osync pulse convention as `piso`/`sipo`. It sits between a bank of `piso` serialisers and a `sipo` deserialiser, and adds end-of-word carry reporting and a per-bit valid strobe.

---
 rtl/serialadd_n.sv | 131 +++++++++++++
 tb/tb_serialadd_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serialadd_n.sv
// serialadd_n
// N-channel bit-serial adder/subtractor. It consumes N LSB-first operand
// streams of LEN bits and produces their signed sum modulo 2^LEN as one
// LSB-first result stream. Each channel can be added or subtracted, and
// that choice is made per word. The result is delayed by exactly one clock.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - synchronous active-high reset
//   a       - current serial bit of each channel (a[k] = channel k)
//   sub     - per-channel subtract select, sampled only when isync=1
//   isync   - one-cycle pulse: bit 0 of a new word is on 'a' this cycle
//   q       - serial result bit, LSB first
//   osync   - one-cycle pulse: result bit 0 is on 'q' this cycle
//   ovalid  - high on every cycle that carries a result bit
//   cy      - high together with result bit LEN-1 when the final carry is nonzero
module serialadd_n #(
    parameter int N   = 4,
    parameter int LEN = 10,
    parameter int CW  = $clog2(N+1)+1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] sub,
    input  logic         isync,
    output logic         q,
    output logic         osync,
    output logic         ovalid,
    output logic         cy
);

    localparam int CNTW = $clog2(LEN+1);
    localparam logic [CNTW-1:0] CNT_IDLE = CNTW'(LEN);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LEN-1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    // The column sum is popcount(e) + carry and can reach 2N, so it needs one
    // bit more than the carry register.
    localparam int SW = CW+1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [CW-1:0]  c, c_n;
    logic [N-1:0]   subl, subl_n;
    logic           q_n, osync_n, ovalid_n, cy_n;

    logic [N-1:0]   m;
    logic [N-1:0]   e;
    logic [CW-1:0]  cin;
    logic [SW-1:0]  s;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < N; k++) begin
            n = n + CW'(v[k]);
        end
        return n;
    endfunction

    // Column arithmetic for the bit being consumed this cycle. On the isync
    // cycle the fresh 'sub' is used directly. Its popcount seeds the carry,
    // which supplies the +1 for each inverted (subtracted) channel. On later
    // bits the latched mode and the running carry take over.
    always_comb begin
        m   = isync ? sub : subl;
        e   = a ^ m;
        cin = isync ? popcount(sub) : c;
        s   = SW'(popcount(e)) + SW'(cin);
    end

    // Next-state and next-output logic. isync always restarts a word at bit 0.
    // This covers both back-to-back words and aborting a word part way through.
    // An aborted word never reaches its last bit, so it never raises cy.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        c_n      = c;
        subl_n   = subl;
        q_n      = 1'b0;
        osync_n  = isync;
        ovalid_n = 1'b0;
        cy_n     = 1'b0;
        if (isync) begin
            state_n  = RUN;
            cnt_n    = CNT_ONE;
            subl_n   = sub;
            c_n      = s[SW-1:1];
            q_n      = s[0];
            ovalid_n = 1'b1;
        end else if (state == RUN) begin
            c_n      = s[SW-1:1];
            q_n      = s[0];
            ovalid_n = 1'b1;
            if (cnt == CNT_LAST) begin
                state_n = IDLE;
                cnt_n   = CNT_IDLE;
                cy_n    = |s[SW-1:1];
            end else begin
                cnt_n = cnt + CNT_ONE;
            end
        end
    end

    // State and output registers. Reset takes priority over a coincident
    // isync, so any word in flight is dropped and no pulses follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= CNT_IDLE;
            c      <= '0;
            subl   <= '0;
            q      <= 1'b0;
            osync  <= 1'b0;
            ovalid <= 1'b0;
            cy     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            c      <= c_n;
            subl   <= subl_n;
            q      <= q_n;
            osync  <= osync_n;
            ovalid <= ovalid_n;
            cy     <= cy_n;
        end
    end

endmodule

// File: tb/tb_serialadd_n.sv
// tb_serialadd_n
// Directed bench for serialadd_n with N=4, LEN=10. A monitor rebuilds each
// result word from osync/ovalid/q and records the cy bit that comes with it.
// Stimulus tasks drive words LSB first on the falling edge.
module tb_serialadd_n;

    localparam int N   = 4;
    localparam int LEN = 10;

    logic         clk;
    logic         reset;
    logic [N-1:0] a;
    logic [N-1:0] sub;
    logic         isync;
    logic         q;
    logic         osync;
    logic         ovalid;
    logic         cy;

    int errors = 0;
    int checks = 0;

    // Monitor bookkeeping
    logic [LEN-1:0] resQ[$];
    logic           cyQ[$];
    int             ovalidCycles = 0;
    int             ovalidRises  = 0;
    int             osyncCount   = 0;
    int             strayCy      = 0;
    int             bitIdx       = LEN;
    logic [LEN-1:0] acc;
    logic           prevOvalid   = 1'b0;

    typedef struct {
        logic [N-1:0][LEN-1:0] ops;
        logic [N-1:0]          mode;
        logic [LEN-1:0]        expQ;
        logic                  expCy;
    } vec_t;

    vec_t vecs[8];

    serialadd_n #(.N(N), .LEN(LEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .sub    (sub),
        .isync  (isync),
        .q      (q),
        .osync  (osync),
        .ovalid (ovalid),
        .cy     (cy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: it samples on the falling edge, away from DUT updates.
    // A word is pushed only when its LEN-th bit arrives. A cy seen on any
    // other cycle is counted as stray.
    initial begin
        forever begin
            @(negedge clk);
            if (osync) osyncCount++;
            if (ovalid && !prevOvalid) ovalidRises++;
            if (ovalid) begin
                ovalidCycles++;
                if (osync) bitIdx = 0;
                if (bitIdx < LEN) begin
                    acc[bitIdx] = q;
                    if (bitIdx == LEN-1) begin
                        resQ.push_back(acc);
                        cyQ.push_back(cy);
                    end else if (cy) begin
                        strayCy++;
                    end
                    bitIdx++;
                end else if (cy) begin
                    strayCy++;
                end
            end else if (cy) begin
                strayCy++;
            end
            prevOvalid = ovalid;
        end
    end

    function automatic vec_t mkVec(input logic [N-1:0][LEN-1:0] ops, input logic [N-1:0] mode,
                                   input logic [LEN-1:0] expQ, input logic expCy);
        vec_t v;
        v.ops   = ops;
        v.mode  = mode;
        v.expQ  = expQ;
        v.expCy = expCy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the first nbits bits of one word, with isync on bit 0. On later
    // bits 'sub' is driven to the complement, which shows whether the DUT
    // really latched the mode. The cycle after isync must show osync.
    task automatic applyStimulus(input logic [N-1:0][LEN-1:0] ops, input logic [N-1:0] mode, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("osync_latency", 32'(osync), 32'd1);
            isync = (i == 0);
            sub   = (i == 0) ? mode : ~mode;
            for (int k = 0; k < N; k++) a[k] = ops[k][i];
        end
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            isync = 1'b0;
            a     = '0;
            sub   = '0;
        end
    endtask

    // Pops one reconstructed word. The wait is bounded, and a timeout counts as a failure.
    task automatic getWord(input string name, output logic [LEN-1:0] r, output logic c, output bit ok);
        ok = 1'b0;
        r  = '0;
        c  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resQ.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            r = resQ.pop_front();
            c = cyQ.pop_front();
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no result word, expected one within 40 cycles", name);
        end
    endtask

    initial begin
        logic [LEN-1:0]        r;
        logic                  c;
        bit                    ok;
        int                    ov0, rs0, os0, sc0;
        logic [N-1:0][LEN-1:0] ops;

        reset = 1'b1;
        isync = 1'b0;
        a     = '0;
        sub   = '0;

        // Hand-computed vectors. ops packs channels as {ch3, ch2, ch1, ch0}.
        vecs[0] = mkVec({10'd4, 10'd3, 10'd2, 10'd1}, 4'b0000, 10'h00A, 1'b0);
        vecs[1] = mkVec({10'd4, 10'd3, 10'd2, 10'd1}, 4'b0001, 10'h008, 1'b1);
        vecs[2] = mkVec({10'd0, 10'd0, 10'd0, 10'd5}, 4'b0001, 10'h3FB, 1'b0);
        vecs[3] = mkVec({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 4'b0000, 10'h3FC, 1'b1);
        vecs[4] = mkVec({10'd1, 10'd1, 10'd1, 10'd1}, 4'b1111, 10'h3FC, 1'b1);
        vecs[5] = mkVec({10'd50, 10'd3, 10'd7, 10'd100}, 4'b0110, 10'h08C, 1'b1);
        vecs[6] = mkVec({10'd0, 10'd0, 10'd0, 10'd0}, 4'b0000, 10'h000, 1'b0);
        vecs[7] = mkVec({10'd0, 10'd0, 10'h200, 10'h200}, 4'b0000, 10'h000, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_osync", 32'(osync), 32'd0);
        checkOutput("reset_ovalid", 32'(ovalid), 32'd0);
        checkOutput("reset_cy", 32'(cy), 32'd0);
        reset = 1'b0;
        applyIdle(2);

        // Single words from the table
        for (int v = 0; v < 8; v++) begin
            ov0 = ovalidCycles;
            rs0 = ovalidRises;
            os0 = osyncCount;
            sc0 = strayCy;
            applyStimulus(vecs[v].ops, vecs[v].mode, LEN);
            applyIdle(3);
            getWord($sformatf("vec%0d_word", v), r, c, ok);
            if (ok) begin
                checkOutput($sformatf("vec%0d_q", v), 32'(r), 32'(vecs[v].expQ));
                checkOutput($sformatf("vec%0d_cy", v), 32'(c), 32'(vecs[v].expCy));
            end
            checkOutput($sformatf("vec%0d_ovalid_len", v), 32'(ovalidCycles - ov0), 32'(LEN));
            checkOutput($sformatf("vec%0d_ovalid_runs", v), 32'(ovalidRises - rs0), 32'd1);
            checkOutput($sformatf("vec%0d_osync_count", v), 32'(osyncCount - os0), 32'd1);
            checkOutput($sformatf("vec%0d_stray_cy", v), 32'(strayCy - sc0), 32'd0);
        end

        // Ten back-to-back words, operands rising by one per word
        ov0 = ovalidCycles;
        rs0 = ovalidRises;
        for (int w = 0; w < 10; w++) begin
            ops = {10'(w + 4), 10'(w + 3), 10'(w + 2), 10'(w + 1)};
            applyStimulus(ops, 4'b0000, LEN);
        end
        applyIdle(3);
        for (int w = 0; w < 10; w++) begin
            getWord($sformatf("b2b%0d_word", w), r, c, ok);
            if (ok) begin
                checkOutput($sformatf("b2b%0d_q", w), 32'(r), 32'(10 + 4 * w));
                checkOutput($sformatf("b2b%0d_cy", w), 32'(c), 32'd0);
            end
        end
        checkOutput("b2b_ovalid_cycles", 32'(ovalidCycles - ov0), 32'd100);
        checkOutput("b2b_ovalid_runs", 32'(ovalidRises - rs0), 32'd1);

        // Abort: a new isync arrives where bit 5 would be. Carry is large at that point.
        os0 = osyncCount;
        sc0 = strayCy;
        applyStimulus({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 4'b0000, 5);
        applyStimulus({10'd4, 10'd3, 10'd2, 10'd1}, 4'b0000, LEN);
        applyIdle(3);
        checkOutput("abort_word_count", 32'(resQ.size()), 32'd1);
        getWord("abort_word", r, c, ok);
        if (ok) begin
            checkOutput("abort_q", 32'(r), 32'h00A);
            checkOutput("abort_cy", 32'(c), 32'd0);
        end
        checkOutput("abort_osync_count", 32'(osyncCount - os0), 32'd2);
        checkOutput("abort_stray_cy", 32'(strayCy - sc0), 32'd0);

        // Reset at bit 4, then isync during reset, then a clean word
        os0 = osyncCount;
        ops = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        applyStimulus(ops, 4'b0000, 4);
        @(negedge clk);
        reset = 1'b1;
        isync = 1'b0;
        for (int k = 0; k < N; k++) a[k] = ops[k][4];
        @(negedge clk);
        checkOutput("midreset_outputs", 32'({q, osync, ovalid, cy}), 32'd0);
        isync = 1'b1;
        a     = 4'b1111;
        @(negedge clk);
        checkOutput("midreset_isync_outputs", 32'({q, osync, ovalid, cy}), 32'd0);
        reset = 1'b0;
        isync = 1'b0;
        a     = '0;
        applyIdle(3);
        checkOutput("midreset_ovalid_idle", 32'(ovalid), 32'd0);
        checkOutput("midreset_no_word", 32'(resQ.size()), 32'd0);
        checkOutput("midreset_osync_count", 32'(osyncCount - os0), 32'd1);
        applyStimulus({10'd4, 10'd3, 10'd2, 10'd1}, 4'b0001, LEN);
        applyIdle(3);
        getWord("postreset_word", r, c, ok);
        if (ok) begin
            checkOutput("postreset_q", 32'(r), 32'h008);
            checkOutput("postreset_cy", 32'(c), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
